// File: rtl/tmr_triplicator.sv
`default_nettype none
// ============================================================================
// Module      : tmr_triplicator
// Description : Transmit side of a triple-redundant link. Accepts one word per
//               valid/ready handshake and loads it into three identical
//               channel registers that feed a majority voter. It holds the
//               channels stable for HOLD_CYCLES and then samples the voter's
//               error flag. On an error it reloads all three channels from
//               the captured word, up to MAX_RETRY times. Each word ends with
//               a one-cycle done or fail pulse.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               in_data/in_valid - upstream word and its valid strobe
//               in_ready         - high while idle (decoded from state)
//               ch1/ch2/ch3      - redundant copies driven to the voter
//               ch_valid         - channels hold a word under test
//               vote_error       - voter flag, sampled only in CHECK
//               done/fail        - one-cycle result pulse per word
//               retries          - reloads used for the current/last word
//               inj_en/inj_sel/inj_mask - fault injection (FAULT_INJECT_EN)
// Config      : define FAULT_INJECT_EN to add the fault-injection ports. The
//               corrupted copy is applied only on the acceptance load.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_triplicator #(
    parameter int WIDTH       = 2,
    parameter int MAX_RETRY   = 3,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             ch_valid,
    input  logic             vote_error,
`ifdef FAULT_INJECT_EN
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
`endif
    output logic             done,
    output logic             fail,
    output logic [3:0]       retries
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;

    localparam logic [3:0] c_MAX_RETRY = 4'(MAX_RETRY);
    localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] r_ch1;
    logic [WIDTH-1:0] r_ch2;
    logic [WIDTH-1:0] r_ch3;
    logic             r_ch_valid;
    logic             r_done;
    logic             r_fail;
    logic [3:0]       r_retries;
    logic [7:0]       r_hold_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_can_retry;
    logic             w_reload;
    logic             w_pass;
    logic             w_giveup;
    logic [WIDTH-1:0] w_load1;
    logic [WIDTH-1:0] w_load2;
    logic [WIDTH-1:0] w_load3;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_next = c_DRIVE;
                end
            end
            c_DRIVE: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_next = c_CHECK;
                end
            end
            c_CHECK: begin
                // Only a still-failing word with retry budget left goes back
                // to DRIVE; pass and give-up both return to IDLE.
                if (vote_error && w_can_retry) begin
                    w_state_next = c_DRIVE;
                end else begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = (r_state == c_IDLE);
        w_accept    = w_in_ready && in_valid;
        w_can_retry = (r_retries < c_MAX_RETRY);
        w_reload    = (r_state == c_CHECK) &&  vote_error &&  w_can_retry;
        w_giveup    = (r_state == c_CHECK) &&  vote_error && !w_can_retry;
        w_pass      = (r_state == c_CHECK) && !vote_error;
    end

    // Values loaded into the channels on acceptance. With fault injection
    // one selected copy may be corrupted; retries never use these values.
    always_comb begin
        w_load1 = in_data;
        w_load2 = in_data;
        w_load3 = in_data;
`ifdef FAULT_INJECT_EN
        if (inj_en) begin
            case (inj_sel)
                2'd1:    w_load1 = in_data ^ inj_mask;
                2'd2:    w_load2 = in_data ^ inj_mask;
                2'd3:    w_load3 = in_data ^ inj_mask;
                default: ;
            endcase
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q   <= '0;
            r_ch1      <= '0;
            r_ch2      <= '0;
            r_ch3      <= '0;
            r_ch_valid <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_retries  <= 4'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_done <= w_pass;
            r_fail <= w_giveup;

            if (w_accept) begin
                r_data_q   <= in_data;
                r_ch1      <= w_load1;
                r_ch2      <= w_load2;
                r_ch3      <= w_load3;
                r_retries  <= 4'd0;
                r_hold_cnt <= c_HOLD_LOAD;
                r_ch_valid <= 1'b1;
            end else if (w_reload) begin
                r_ch1      <= r_data_q;
                r_ch2      <= r_data_q;
                r_ch3      <= r_data_q;
                r_retries  <= r_retries + 4'd1;
                r_hold_cnt <= c_HOLD_LOAD;
            end else if ((r_state == c_DRIVE) && (r_hold_cnt != 8'd0)) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end

            // Channels keep their last word; only the valid flag drops.
            if (w_pass || w_giveup) begin
                r_ch_valid <= 1'b0;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign ch1      = r_ch1;
    assign ch2      = r_ch2;
    assign ch3      = r_ch3;
    assign ch_valid = r_ch_valid;
    assign done     = r_done;
    assign fail     = r_fail;
    assign retries  = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_tmr_triplicator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_triplicator
// Description : Self-checking bench for tmr_triplicator (WIDTH=2,
//               MAX_RETRY=3, HOLD_CYCLES=1) with a behavioural majority
//               voter attached. Expected results are queued at acceptance
//               and checked when the done/fail pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_triplicator;

    logic       clk;
    logic       rst;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ch1;
    logic [1:0] ch2;
    logic [1:0] ch3;
    logic       ch_valid;
    logic       vote_error;
    logic       done;
    logic       fail;
    logic [3:0] retries;
    logic       force_err;
`ifdef FAULT_INJECT_EN
    logic       inj_en;
    logic [1:0] inj_sel;
    logic [1:0] inj_mask;
`endif

    typedef struct {
        logic [1:0] data;
        bit         is_fail;
        logic [3:0] r;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;
    int   cyc;
    int   last_done_cyc;

    tmr_triplicator #(
        .WIDTH       (2),
        .MAX_RETRY   (3),
        .HOLD_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch_valid   (ch_valid),
        .vote_error (vote_error),
`ifdef FAULT_INJECT_EN
        .inj_en     (inj_en),
        .inj_sel    (inj_sel),
        .inj_mask   (inj_mask),
`endif
        .done       (done),
        .fail       (fail),
        .retries    (retries)
    );

    // Voter: error when no two channels agree, or when forced by the bench.
    assign vote_error = force_err || !((ch1 == ch2) || (ch1 == ch3) || (ch2 == ch3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Result monitor: every done/fail pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && (done || fail)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'd0, done, fail}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("not_both",     {31'd0, done && fail}, 32'd0);
                chk("fail_pulse",   {31'd0, fail},         {31'd0, e.is_fail});
                chk("done_pulse",   {31'd0, done},         {31'd0, !e.is_fail});
                chk("retries_end",  {28'd0, retries},      {28'd0, e.r});
                chk("latency",      cyc,                   e.cyc);
                chk("ch1_hold",     {30'd0, ch1},          {30'd0, e.data});
                chk("ch_valid_end", {31'd0, ch_valid},     32'd0);
                last_done_cyc = cyc;
            end
        end
    end

    // Offer a word once in_ready is seen; returns the cycle count just after
    // the accepting edge. HOLD_CYCLES=1: pulse visible HOLD+1 cycles later,
    // plus HOLD+1 per retry.
    task automatic send(input logic [1:0] d, input bit push, input bit is_fail,
                        input logic [3:0] r, output int acc_cyc);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (push) begin
            e.data    = d;
            e.is_fail = is_fail;
            e.r       = r;
            e.cyc     = cyc + 2 + 2 * int'(r);
            sb.push_back(e);
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int a1;
        int a2;
        n_pass        = 0;
        n_total       = 0;
        last_done_cyc = -1;
        rst           = 1'b1;
        in_data       = 2'b00;
        in_valid      = 1'b0;
        force_err     = 1'b0;
`ifdef FAULT_INJECT_EN
        inj_en   = 1'b0;
        inj_sel  = 2'd0;
        inj_mask = 2'b00;
`endif

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("rst_ch1",      {30'd0, ch1},      32'd0);
        chk("rst_ch2",      {30'd0, ch2},      32'd0);
        chk("rst_ch3",      {30'd0, ch3},      32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_fail",     {31'd0, fail},     32'd0);
        chk("rst_retries",  {28'd0, retries},  32'd0);

        // 2: clean word, no retry
        send(2'b10, 1'b1, 1'b0, 4'd0, a1);
        chk("load_ch1",      {30'd0, ch1},      32'h2);
        chk("load_ch2",      {30'd0, ch2},      32'h2);
        chk("load_ch3",      {30'd0, ch3},      32'h2);
        chk("load_ch_valid", {31'd0, ch_valid}, 32'd1);
        chk("load_ready",    {31'd0, in_ready}, 32'd0);
        chk("load_retries",  {28'd0, retries},  32'd0);
        wait_empty();

        // 3: error forced for two checks, then clear -> done after 2 reloads
        force_err = 1'b1;
        send(2'b01, 1'b1, 1'b0, 4'd2, a1);
        repeat (4) @(posedge clk);
        #1;
        force_err = 1'b0;
        wait_empty();

        // 4: error stuck high -> fail after 3 reloads
        force_err = 1'b1;
        send(2'b11, 1'b1, 1'b1, 4'd3, a1);
        wait_empty();
        force_err = 1'b0;

        // 5: back-to-back words; second accepted while done(00) is high
        send(2'b00, 1'b1, 1'b0, 4'd0, a1);
        send(2'b11, 1'b1, 1'b0, 4'd0, a2);
        chk("b2b_accept_cyc", a2, last_done_cyc + 1);
        chk("b2b_ch1",        {30'd0, ch1}, 32'h3);
        chk("b2b_ch2",        {30'd0, ch2}, 32'h3);
        chk("b2b_ch3",        {30'd0, ch3}, 32'h3);
        wait_empty();

        // 6: reset during DRIVE drops the word without a pulse
        send(2'b01, 1'b0, 1'b0, 4'd0, a1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready",    {31'd0, in_ready}, 32'd1);
        chk("midrst_ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("midrst_ch1",      {30'd0, ch1},      32'd0);
        chk("midrst_done",     {31'd0, done},     32'd0);
        chk("midrst_fail",     {31'd0, fail},     32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_quiet_ready", {31'd0, in_ready}, 32'd1);

`ifdef FAULT_INJECT_EN
        // Fault injection on channel 2 is outvoted; word still verifies.
        inj_en   = 1'b1;
        inj_sel  = 2'd2;
        inj_mask = 2'b01;
        send(2'b10, 1'b1, 1'b0, 4'd0, a1);
        inj_en   = 1'b0;
        chk("inj_ch1", {30'd0, ch1}, 32'h2);
        chk("inj_ch2", {30'd0, ch2}, 32'h3);
        chk("inj_ch3", {30'd0, ch3}, 32'h2);
        wait_empty();
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
